// File: rtl/spi_pkt_pkg.sv
// Shared definitions for the serial packet deframer: FSM state encoding,
// default framing constants and a saturating counter helper.
package spi_pkt_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_SKIP    = 3'd4
    } pkt_state_e;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         DEF_MAX_LEN   = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_byte_deser.sv
// Serial-to-byte deserializer: LSB-first 8-bit frames qualified by cs.
// A frame cut short by cs dropping is discarded and flagged for one cycle.
module spi_byte_deser (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cs_i,
    input  logic       data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frm_err_o
);

    logic [2:0] cnt_q;
    logic [7:0] shift_q;
    logic [7:0] byte_q;
    logic       byte_valid_q;
    logic       frm_err_q;

    // Shift in one bit per cs-high cycle; publish the byte on the 8th bit.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frm_err_q    <= 1'b0;
            if (cs_i) begin
                shift_q <= {data_i, shift_q[7:1]};
                cnt_q   <= cnt_q + 3'd1;  // wraps to 0 so a held cs starts a new byte
                if (cnt_q == 3'd7) begin
                    byte_q       <= {data_i, shift_q[7:1]};
                    byte_valid_q <= 1'b1;
                end
            end else if (cnt_q != 3'd0) begin
                cnt_q     <= '0;
                frm_err_q <= 1'b1;
            end
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frm_err_o    = frm_err_q;

endmodule

// File: rtl/spi_pkt_deframer.sv
// Packet deframer: hunts for SYNC, LEN, payload, CSUM on the byte stream,
// stores payload speculatively and releases it to the output stream only
// after the checksum matches (store-and-forward).
module spi_pkt_deframer
    import spi_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         MAX_LEN   = DEF_MAX_LEN,
    parameter int         BUF_DEPTH = 32,
    parameter int         TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        link_cs,
    input  logic        link_data,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_err_cnt,
    output logic        frm_err,
    output logic        busy
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [7:0]  rx_byte;
    logic        rx_valid;

    pkt_state_e  state_q, state_d;
    logic [PW-1:0] wr_q, wr_d;      // speculative write pointer
    logic [PW-1:0] cm_q, cm_d;      // committed pointer
    logic [PW-1:0] rd_q, rd_d;      // read pointer
    logic [8:0]  cnt_q, cnt_d;      // bytes remaining in PAYLOAD / SKIP
    logic [7:0]  csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0] ok_q, ok_d;
    logic [15:0] err_q, err_d;

    logic [PW-1:0] free_w;
    logic        wr_en;
    logic [8:0]  wr_word;
    logic [8:0]  rd_word;
    logic [8:0]  mem [BUF_DEPTH];

    spi_byte_deser u_deser (
        .clk          (clk),
        .resetn       (resetn),
        .cs_i         (link_cs),
        .data_i       (link_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frm_err_o    (frm_err)
    );

    assign free_w  = PW'(BUF_DEPTH) - (wr_q - rd_q);
    assign wr_word = {(cnt_q == 9'd1), rx_byte};

    // Packet FSM, pointer management, timeout and counters.
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cm_d    = cm_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        tmo_d   = '0;
        ok_d    = ok_q;
        err_d   = err_q;
        wr_en   = 1'b0;

        if (m_valid && m_ready) rd_d = rd_q + PW'(1);

        if (state_q != ST_HUNT && !rx_valid) tmo_d = tmo_q + TW'(1);

        case (state_q)
            ST_HUNT: begin
                if (rx_valid && rx_byte == SYNC_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_byte == 8'd0 || 32'(rx_byte) > 32'(MAX_LEN)) begin
                        state_d = ST_HUNT;
                        err_d   = sat_inc(err_q);
                    end else if (32'(free_w) < 32'(rx_byte)) begin
                        // No room: drain payload plus checksum without storing.
                        state_d = ST_SKIP;
                        err_d   = sat_inc(err_q);
                        cnt_d   = {1'b0, rx_byte} + 9'd1;
                    end else begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = {1'b0, rx_byte};
                        csum_d  = rx_byte;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    wr_en  = 1'b1;
                    wr_d   = wr_q + PW'(1);
                    csum_d = csum_q ^ rx_byte;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    state_d = ST_HUNT;
                    if (rx_byte == csum_q) begin
                        cm_d = wr_q;
                        ok_d = sat_inc(ok_q);
                    end else begin
                        wr_d  = cm_q;
                        err_d = sat_inc(err_q);
                    end
                end
            end
            ST_SKIP: begin
                if (rx_valid) begin
                    cnt_d = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // A stalled link mid-packet abandons it; no byte arrives this cycle,
        // so nothing above has touched the pointers or counters.
        if (state_q != ST_HUNT && !rx_valid && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_HUNT;
            wr_d    = cm_q;
            err_d   = sat_inc(err_q);
            tmo_d   = '0;
        end
    end

    // State registers; reset discards committed and uncommitted data alike.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_HUNT;
            wr_q    <= '0;
            cm_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            ok_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cm_q    <= cm_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    // Payload buffer write port.
    // NOTE: the RAM array has no reset; pointer reset alone makes its
    // contents unreachable, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= wr_word;
    end

    assign rd_word     = mem[rd_q[AW-1:0]];
    assign m_valid     = (rd_q != cm_q);
    assign m_data      = m_valid ? rd_word[7:0] : 8'h00;
    assign m_last      = m_valid & rd_word[8];
    assign busy        = (state_q != ST_HUNT);
    assign pkt_ok_cnt  = ok_q;
    assign pkt_err_cnt = err_q;

endmodule
